// File: rtl/flash_fetch.sv
// rtl/flash_fetch.sv - serial flash read engine: sends {CMD_READ, addr}, shifts in DATA_BITS of data
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   req_valid/req_addr      read request (24-bit byte address), taken when req_ready=1
//   req_ready               high only while idle
//   flash_clk               serial clock from the external generator (runs only while clk_en=1)
//   clk_en                  enables the flash clock generator during command and data phases
//   flash_cs_n              chip select, active low for the whole transfer
//   flash_mosi              command/address bit out, MSB first
//   flash_miso              data bit in, sampled on flash_clk rising edges
//   data_out/data_valid     fetched word (first bit in MSB), valid until data_ready
//   data_ready              consumer acknowledge
module flash_fetch #(
  parameter logic [7:0] CMD_READ  = 8'h03,
  parameter int          DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [23:0]          req_addr,
  output logic                 req_ready,
  input  logic                 flash_clk,
  output logic                 clk_en,
  output logic                 flash_cs_n,
  output logic                 flash_mosi,
  input  logic                 flash_miso,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready
);

  typedef enum logic [1:0] {IDLE, SEND_CMD, FETCH_BIT, DONE} state_t;

  localparam logic [5:0] CMD_LAST = 6'd31;
  localparam logic [5:0] DATA_CNT = 6'(DATA_BITS);

  state_t               state;
  state_t               next_state;
  logic                 clk_prev;
  logic                 rise;
  logic                 fall;
  logic                 accept;
  logic [31:0]          cmd_sr;
  logic [DATA_BITS-1:0] data_sr;
  logic [5:0]           bit_cnt;

  // flash_clk is generated off clk, so a one-cycle delayed copy is enough to find its edges
  assign rise   = flash_clk & ~clk_prev;
  assign fall   = ~flash_clk & clk_prev;
  assign accept = req_valid & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = SEND_CMD;
      SEND_CMD:  if (rise && bit_cnt == CMD_LAST) next_state = FETCH_BIT;
      // the last data bit is taken on a rise; leaving on the following fall
      // keeps flash_clk low when the generator is switched off
      FETCH_BIT: if (fall && bit_cnt == DATA_CNT) next_state = DONE;
      DONE:      if (data_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    clk_en     = 1'b0;
    flash_cs_n = 1'b1;
    flash_mosi = 1'b0;
    data_valid = 1'b0;
    case (state)
      IDLE:      req_ready = 1'b1;
      SEND_CMD:  begin
        clk_en     = 1'b1;
        flash_cs_n = 1'b0;
        flash_mosi = cmd_sr[31];
      end
      FETCH_BIT: begin
        clk_en     = 1'b1;
        flash_cs_n = 1'b0;
      end
      DONE:      data_valid = 1'b1;
      default:   req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev <= 1'b0;
      cmd_sr   <= '0;
      data_sr  <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
    end else begin
      clk_prev <= flash_clk;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_sr  <= {CMD_READ, req_addr};
            data_sr <= '0;
            bit_cnt <= '0;
          end
        end
        SEND_CMD: begin
          if (rise) bit_cnt <= (bit_cnt == CMD_LAST) ? 6'd0 : bit_cnt + 6'd1;
          // shifting on the fall gives the flash a full half period of setup before its rise
          if (fall) cmd_sr <= {cmd_sr[30:0], 1'b0};
        end
        FETCH_BIT: begin
          if (rise && bit_cnt != DATA_CNT) begin
            data_sr <= (data_sr << 1) | DATA_BITS'(flash_miso);
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (fall && bit_cnt == DATA_CNT) data_out <= data_sr;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_fetch.md
FLASH_FETCH -- requirements
Module: flash_fetch

Interface
REQ-001 Parameter CMD_READ, default 8'h03: flash read opcode sent first, MSB-first.
REQ-002 Parameter DATA_BITS, default 32: number of data bits fetched per request, legal range 1..32.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_addr  input  24  flash byte address, sampled on accept.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 flash_clk  input  1  serial clock from the flash clock generator; free-running only while clk_en=1, low otherwise.
REQ-009 clk_en  output  1  enables the flash clock generator; generator holds flash_clk=0 and its counter at 0 when clk_en=0.
REQ-010 flash_cs_n  output  1  flash chip select, active low.
REQ-011 flash_mosi  output  1  serial command/address out.
REQ-012 flash_miso  input  1  serial data in.
REQ-013 data_out  output  DATA_BITS  fetched word, first received bit in the MSB.
REQ-014 data_valid  output  1  data_out holds a completed fetch.
REQ-015 data_ready  input  1  consumer accepts data_out.

Function
REQ-016 States SHALL be IDLE, SEND_CMD, FETCH_BIT, DONE, encoded as a registered state.
REQ-017 Edge detect SHALL use a one-cycle registered copy of flash_clk: rise = flash_clk & ~prev; fall = ~flash_clk & prev; edges SHALL be ignored in IDLE and DONE.
REQ-018 req_ready SHALL be 1 only in IDLE; accept = req_valid & req_ready.
REQ-019 On accept: 32-bit shift register loaded with {CMD_READ, req_addr}, bit counter cleared, state moves to SEND_CMD, flash_cs_n driven 0 on the same edge.
REQ-020 clk_en SHALL be 1 exactly in SEND_CMD and FETCH_BIT, so flash_clk runs continuously across the command and data phases.
REQ-021 flash_mosi SHALL equal shift register bit 31 in SEND_CMD, valid before the first rise; register shifts left by one on each fall; flash_mosi=0 in all other states.
REQ-022 In SEND_CMD the bit counter SHALL increment on each rise; on the 32nd rise the counter clears and state moves to FETCH_BIT.
REQ-023 In FETCH_BIT flash_miso SHALL be shifted into the LSB of a data shift register on each rise, and the counter increments.
REQ-024 After the DATA_BITS-th rise in FETCH_BIT, the next fall SHALL move to DONE; flash_cs_n=1 and clk_en=0 from DONE onward; data_out is loaded from the data shift register.
REQ-025 data_valid SHALL be 1 exactly in DONE; data_out stable while data_valid=1.
REQ-026 In DONE, data_ready=1 SHALL return the block to IDLE on the next edge; data_valid drops and req_ready rises in the same cycle.
REQ-027 A request is accepted no earlier than the cycle after the DONE to IDLE transition; no back-to-back overlap.
REQ-028 req_valid and req_addr changes outside IDLE SHALL have no effect.
REQ-029 Bit counter SHALL be 6 bits wide and never exceed 32.

Reset
REQ-030 On reset assertion, without waiting for clk: state=IDLE, req_ready=1, clk_en=0, flash_cs_n=1, flash_mosi=0, data_valid=0, data_out=0, shift registers, counter and edge-detect register =0.
REQ-031 Reset mid-transfer SHALL abort immediately: flash_cs_n=1 at reset assertion, no data_valid pulse afterwards.
REQ-032 After reset deasserts, first accept is possible on the first posedge clk.

Verification
REQ-033 Generator period 10, duty 5; req_addr=24'h123456 -> mosi bit sequence 0x03123456 MSB-first, one bit per flash_clk period, cs_n low throughout.
REQ-034 Flash model returns 32'hDEADBEEF after the 32nd command rise -> data_out=32'hDEADBEEF, data_valid=1, cs_n=1, clk_en=0.
REQ-035 data_ready held 0 for 20 cycles in DONE -> data_valid and data_out held constant; then data_ready=1 -> IDLE next cycle, req_ready=1.
REQ-036 Reset asserted at the 10th data bit -> cs_n=1, clk_en=0 with no clock edge, no data_valid; a fresh request then completes correctly.
REQ-037 req_valid toggled and req_addr changed during SEND_CMD -> transmitted address unchanged, no second transfer started.
REQ-038 DATA_BITS=8, flash returns 8'hA5 -> data_out=8'hA5 after exactly 8 data rises plus one fall.
